// File: rtl/serial_word_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_collector_pkg
// Purpose  : Shared state type, default word width and counter sizing helper.
// Revision : 1.0
// ============================================================================
package serial_word_collector_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // Matches the upstream universal shift register width.
  localparam int unsigned DEFAULT_WIDTH = 4;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : word_fifo2
// Purpose  : Two-entry valid/ready word buffer with registered head and
//            overflow reporting.
// Revision : 1.0
// ============================================================================
module word_fifo2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             overflow_o,
  output logic             overflow_sticky_o
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic             w_pop;

  assign w_pop = (cnt_q != 2'd0) && ready_i;

  always_comb begin
    cnt_d    = cnt_q;
    head_d   = head_q;
    tail_d   = tail_q;
    ovf_d    = 1'b0;
    sticky_d = sticky_q;
    case ({push_i, w_pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = push_data_i;
          cnt_d  = 2'd1;
        end else if (cnt_q == 2'd1) begin
          tail_d = push_data_i;
          cnt_d  = 2'd2;
        end else begin
          ovf_d    = 1'b1;
          sticky_d = 1'b1;
        end
      end
      2'b01: begin
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; a pop implies at least one entry held.
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_data_i;
        end else begin
          head_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  assign head_o            = head_q;
  assign valid_o           = (cnt_q != 2'd0);
  assign overflow_o        = ovf_q;
  assign overflow_sticky_o = sticky_q;

endmodule
`default_nettype wire

// File: rtl/serial_word_collector.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_collector
// Purpose  : Frames a serial bit stream into WIDTH-bit words and hands them
//            out through a two-entry valid/ready buffer.
// Revision : 1.0
// ============================================================================
module serial_word_collector
  import serial_word_collector_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_din,
  input  logic             s_din_valid,
  input  logic             start,
  output logic [WIDTH-1:0] word_dout,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overflow,
  output logic             overflow_sticky
);

  localparam int unsigned    CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_fresh;
  logic             w_push;

  if (MSB_FIRST) begin : g_msb_first
    assign w_shift = {acc_q[WIDTH-2:0], s_din};
    assign w_fresh = {{(WIDTH-1){1'b0}}, s_din};
  end else begin : g_lsb_first
    assign w_shift = {s_din, acc_q[WIDTH-1:1]};
    assign w_fresh = {s_din, {(WIDTH-1){1'b0}}};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    frame_err_d = 1'b0;
    w_push      = 1'b0;
    if (s_din_valid) begin
      if (start) begin
        // A start always opens a new word; inside a word it aborts the old one.
        frame_err_d = (state_q == ST_COLLECT);
        state_d     = ST_COLLECT;
        cnt_d       = CW'(1);
        acc_d       = w_fresh;
      end else if (state_q == ST_COLLECT) begin
        acc_d = w_shift;
        if (cnt_q == LAST_CNT) begin
          w_push  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      frame_err_q <= frame_err_d;
    end
  end

  word_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk               (clk),
    .rst_n             (rst_n),
    .push_i            (w_push),
    .push_data_i       (w_shift),
    .ready_i           (word_ready),
    .head_o            (word_dout),
    .valid_o           (word_valid),
    .overflow_o        (overflow),
    .overflow_sticky_o (overflow_sticky)
  );

  assign busy      = (state_q == ST_COLLECT);
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_collector
// Purpose  : Scoreboard bench driving MSB-first and LSB-first collectors with
//            one shared serial stream.
// Revision : 1.0
// ============================================================================
module tb_serial_word_collector;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_din = 1'b0;
  logic s_din_valid = 1'b0;
  logic start = 1'b0;
  logic word_ready = 1'b0;

  logic [W-1:0] dout1, dout0;
  logic valid1, valid0, busy1, busy0, fe1, fe0, ovf1, ovf0, st1, st0;

  int total = 0;
  int bad = 0;

  // Reference model state
  int           occ = 0;
  bit           exp_fe = 0, exp_ovf = 0, exp_sticky = 0, exp_busy = 0;
  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp0_q[$];
  int           bits[$];

  always #5 clk = ~clk;

  serial_word_collector #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .s_din(s_din), .s_din_valid(s_din_valid),
    .start(start), .word_dout(dout1), .word_valid(valid1),
    .word_ready(word_ready), .busy(busy1), .frame_err(fe1),
    .overflow(ovf1), .overflow_sticky(st1)
  );

  serial_word_collector #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .s_din(s_din), .s_din_valid(s_din_valid),
    .start(start), .word_dout(dout0), .word_valid(valid0),
    .word_ready(word_ready), .busy(busy0), .frame_err(fe0),
    .overflow(ovf0), .overflow_sticky(st0)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a frame is the list of bits since the last start; a full frame
  // becomes a word, accepted if the two-slot buffer has room after any pop.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        occ = 0; exp_fe = 0; exp_ovf = 0; exp_sticky = 0; exp_busy = 0;
        bits.delete(); exp1_q.delete(); exp0_q.delete();
      end else begin
        bit pop, push;
        logic [W-1:0] w1, w0;
        pop = (occ > 0) && word_ready;
        push = 0; exp_fe = 0; exp_ovf = 0; w1 = '0; w0 = '0;
        if (s_din_valid) begin
          if (start) begin
            if (bits.size() > 0) exp_fe = 1;
            bits.delete();
            bits.push_back(int'(s_din));
          end else if (bits.size() > 0) begin
            bits.push_back(int'(s_din));
            if (bits.size() == W) begin
              for (int i = 0; i < W; i++) begin
                w1[W-1-i] = bits[i][0];
                w0[i]     = bits[i][0];
              end
              push = 1;
              bits.delete();
            end
          end
        end
        if (pop) occ--;
        if (push) begin
          if (occ < 2) begin
            occ++;
            exp1_q.push_back(w1);
            exp0_q.push_back(w0);
          end else begin
            exp_ovf = 1;
            exp_sticky = 1;
          end
        end
        exp_busy = (bits.size() > 0);
      end
    end
  end

  task automatic check_dut(input int k, input logic [W-1:0] dout, input logic v,
                           input logic b, input logic fe, input logic ov,
                           input logic st);
    string s;
    s = (k == 1) ? "msb" : "lsb";
    if (!rst_n) begin
      chk({s, ".rst_valid"}, int'(v), 0);
      chk({s, ".rst_busy"}, int'(b), 0);
      chk({s, ".rst_frame_err"}, int'(fe), 0);
      chk({s, ".rst_overflow"}, int'(ov), 0);
      chk({s, ".rst_sticky"}, int'(st), 0);
      chk({s, ".rst_dout"}, int'(dout), 0);
    end else begin
      chk({s, ".valid"}, int'(v), int'(occ > 0));
      chk({s, ".busy"}, int'(b), int'(exp_busy));
      chk({s, ".frame_err"}, int'(fe), int'(exp_fe));
      chk({s, ".overflow"}, int'(ov), int'(exp_ovf));
      chk({s, ".sticky"}, int'(st), int'(exp_sticky));
      if (v && word_ready) begin
        if (k == 1) begin
          if (exp1_q.size() == 0) chk({s, ".unexpected_word"}, int'(dout), -1);
          else chk({s, ".word"}, int'(dout), int'(exp1_q.pop_front()));
        end else begin
          if (exp0_q.size() == 0) chk({s, ".unexpected_word"}, int'(dout), -1);
          else chk({s, ".word"}, int'(dout), int'(exp0_q.pop_front()));
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_dut(1, dout1, valid1, busy1, fe1, ovf1, st1);
      check_dut(0, dout0, valid0, busy0, fe0, ovf0, st0);
    end
  end

  task automatic drive(input logic v, input logic st, input logic b);
    s_din_valid = v; start = st; s_din = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_din_valid = 1'b0; start = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [W-1:0] v, input bit ready_on_last);
    for (int i = 0; i < W; i++) begin
      if (i == W - 1 && ready_on_last) word_ready = 1'b1;
      drive(1'b1, i == 0, v[W-1-i]);
    end
    s_din_valid = 1'b0; start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Basic word, both bit orders
    word_ready = 1'b1;
    send_word(4'b1011, 0);
    idle(3);

    // Gapped partial word aborted by a new start
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    idle(5);
    send_word(4'hF, 0);
    idle(3);

    // Backpressure and overflow
    word_ready = 1'b0;
    send_word(4'h3, 0);
    send_word(4'h5, 0);
    send_word(4'h9, 0);
    idle(2);
    word_ready = 1'b1;
    idle(4);

    // Push and pop together while full
    word_ready = 1'b0;
    send_word(4'h3, 0);
    send_word(4'h5, 0);
    send_word(4'h9, 1);
    idle(5);

    // Asynchronous reset between edges with a partial word and a buffered word
    word_ready = 1'b0;
    send_word(4'h6, 0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    s_din_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async.msb_valid", int'(valid1), 0);
    chk("async.msb_busy", int'(busy1), 0);
    chk("async.msb_sticky", int'(st1), 0);
    chk("async.lsb_valid", int'(valid0), 0);
    chk("async.lsb_busy", int'(busy0), 0);
    chk("async.lsb_sticky", int'(st0), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    word_ready = 1'b1;
    idle(4);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) word_ready = ($urandom_range(0, 2) != 0);
      else if ($urandom_range(0, 7) == 0) word_ready = ~word_ready;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
            1'($urandom_range(0, 1)));
    end

    word_ready = 1'b1;
    idle(10);
    chk("drain.msb_left", exp1_q.size(), 0);
    chk("drain.lsb_left", exp0_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
Downstream deserializer for the 4-bit universal shift register's serial outputs (s_right_dout during left shift, s_left_dout during right shift).
- Collects a framed serial bit stream into WIDTH-bit words.
- Buffers up to two completed words.
- Hands words to the consumer over a valid/ready handshake.
- Flags framing errors and overflow.

Parameters:
WIDTH, 4, bits per word; must match the upstream register width; legal range 2..16
MSB_FIRST, 1, 1 = first received bit lands in word bit WIDTH-1 (left-shift source); 0 = first bit lands in bit 0 (right-shift source)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low
s_din  in  1  serial data bit
s_din_valid  in  1  s_din is a valid bit this cycle
start  in  1  frame-start marker; qualified only when s_din_valid=1; that bit is bit 0 of a new word
word_dout  out  WIDTH  buffer head word
word_valid  out  1  buffer non-empty
word_ready  in  1  consumer accepts head word when word_valid=1
busy  out  1  partial word in progress (state COLLECT)
frame_err  out  1  one-cycle pulse: partial word aborted
overflow  out  1  one-cycle pulse: completed word dropped because buffer full
overflow_sticky  out  1  set on any overflow; cleared only by reset

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. Reset asserts immediately, independent of clk; deassertion is sampled on clk.
- Reset values:
  - state IDLE; bit count 0; shift accumulator 0.
  - Buffer empty; word_dout 0.
  - word_valid, busy, frame_err, overflow, overflow_sticky all 0.
- Reset mid-word discards the partial word and all buffered words.
- FSM states: IDLE, COLLECT.
- IDLE:
  - Bits with start=0 are ignored.
  - start=1 with s_din_valid=1: capture bit, count=1, go to COLLECT.
  - WIDTH rule for that start bit: WIDTH>=2, so it never completes a word by itself.
- COLLECT:
  - Each s_din_valid=1 with start=0 captures a bit and increments count.
  - When count reaches WIDTH: push the word to the buffer, count=0, return to IDLE.
  - s_din_valid=0: hold state; no timeout.
- Start inside COLLECT (s_din_valid=1 and start=1):
  - Discard the partial word and pulse frame_err for one cycle.
  - Treat the bit as bit 0 of a new word: count=1, stay in COLLECT.
- Bit placement:
  - MSB_FIRST=1: accumulator shifts left, new bit enters at LSB. After WIDTH bits, the first bit is at WIDTH-1.
  - MSB_FIRST=0: accumulator shifts right, new bit enters at MSB. After WIDTH bits, the first bit is at bit 0.
- Latency: word_valid and word_dout reflect a completed word on the clock edge after the last bit is captured, i.e. visible the cycle after the last s_din_valid.
- Buffer: 2-entry FIFO with a registered output head.
  - A pop occurs when word_valid and word_ready are both 1.
  - Push into a full buffer with no pop the same cycle: drop the new word, pulse overflow, set overflow_sticky. Buffered words are unchanged.
  - Push and pop in the same cycle while full: accepted; the buffer stays full and no overflow is raised.
  - Push and pop in the same cycle with one entry held: the new word becomes the head next cycle.
  - Push and pop in the same cycle with the buffer empty: not possible.
  - word_dout holds its value while word_valid=1 and word_ready=0.
  - word_dout when the buffer is empty: last value; don't-care for checkers.
- busy=1 exactly while state=COLLECT.

Decomposition:
- Shared package holds:
  - State enum for IDLE and COLLECT.
  - Default-width constant (4), shared with the universal register.
  - Count-width function: clog2(WIDTH+1).
- One natural sub-module: word_fifo2, a 2-entry valid/ready buffer parameterised by WIDTH. It owns the push/pop/full/overflow logic.
- The FSM and accumulator stay in the top module.

Test Plan:
1. Reset and basic word:
   - Stimulus: rst_n low then high; MSB_FIRST=1; send bits 1,0,1,1 on consecutive cycles with start on the first bit; word_ready=1.
   - Response: all outputs 0 during reset; word_dout=4'b1011 with word_valid=1 one cycle after the 4th bit, then word_valid drops.
2. Bit order:
   - Stimulus: MSB_FIRST=0 instance; same bits 1,0,1,1.
   - Response: word_dout=4'b1101.
3. Gapped bits and abort:
   - Stimulus: start + 2 bits, idle 5 cycles (s_din_valid=0), then start + 1,1,1,1.
   - Response: frame_err pulses once on the second start; single word 4'b1111; busy stays high across the gap.
4. Backpressure and overflow:
   - Stimulus: word_ready=0; send three words A=4'h3, B=4'h5, C=4'h9.
   - Response: A and B buffered; C dropped with an overflow pulse and overflow_sticky=1; raising word_ready yields A then B, then word_valid=0.
5. Simultaneous push and pop when full:
   - Stimulus: buffer full with A and B; word_ready=1 in the cycle C completes.
   - Response: no overflow; outputs A, B, C in order.
6. Asynchronous reset mid-word:
   - Stimulus: assert rst_n low between clock edges after 2 bits, with one word buffered.
   - Response: word_valid, busy and overflow_sticky go 0 immediately, before the next clk edge; no word emerges after release.
